dat_timeout_ctrl: RTL

DAT_TIMEOUT_CTRL -- requirements
Module: dat_timeout_ctrl

---
 rtl/sdhci_pkg.sv | 26 ++
 rtl/dat_timeout.sv | 38 +++
 rtl/dat_timeout_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sdhci_pkg.sv
// Shared SD host controller definitions: DAT-path FSM states and timeout
// encoding constants used by the data timeout controller and its timer.
package sdhci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RX_BLOCK,
        ST_TX_WAIT_BUF,
        ST_TX_BLOCK,
        ST_WAIT_BUSY,
        ST_GAP,
        ST_ERROR
    } dat_state_e;

    // 0xF is a reserved timeout code; it behaves like the largest legal one.
    localparam logic [3:0] TIMEOUT_BITS_MAX = 4'hE;

    // Threshold is 2^(bits + TIMEOUT_BASE_SHIFT) clock cycles.
    localparam int unsigned TIMEOUT_BASE_SHIFT = 13;

    function automatic logic [3:0] clamp_timeout_bits(input logic [3:0] bits);
        return (bits > TIMEOUT_BITS_MAX) ? TIMEOUT_BITS_MAX : bits;
    endfunction

endpackage

// File: rtl/dat_timeout.sv
// Data timeout timer: counts cycles while running_i is high, clears whenever
// it is low, and flags timeout_o in the last cycle before the threshold so
// the controller enters ERROR exactly 2^(bits+13) cycles after the start.
module dat_timeout
    import sdhci_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 28
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       running_i,
    input  logic [3:0] timeout_bits_i,
    output logic       timeout_o
);

    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] last;
    logic [4:0]               shamt;

    // Shift needs 5 bits: clamped code 14 + 13 = 27.
    assign shamt = {1'b0, clamp_timeout_bits(timeout_bits_i)} + 5'(TIMEOUT_BASE_SHIFT);
    assign last  = (COUNTER_WIDTH'(1) << shamt) - COUNTER_WIDTH'(1);

    // >= keeps the flag sticky if the code shrinks while a wait is in progress.
    assign timeout_o = running_i && (count >= last);

    // Counter: cleared while idle, saturating at the terminal count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (!running_i) begin
            count <= '0;
        end else if (count < last) begin
            count <= count + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/dat_timeout_ctrl.sv
// DAT line transfer sequencer: tracks block progress for reads and writes,
// handles stop-at-block-gap, and raises a data timeout error when the card
// fails to send a start bit or release DAT0 busy in time.
module dat_timeout_ctrl
    import sdhci_pkg::*;
#(
    parameter int unsigned TIMEOUT_COUNTER_WIDTH = 28
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  timeout_bits_i,
    input  logic        xfer_start_i,
    input  logic        dir_read_i,
    input  logic        multi_block_i,
    input  logic [15:0] block_count_i,
    input  logic        buffer_ready_i,
    input  logic        dat_start_bit_i,
    input  logic        block_done_i,
    input  logic        dat0_busy_i,
    input  logic        stop_at_gap_i,
    input  logic        continue_i,
    input  logic        abort_i,
    output logic        xfer_active_o,
    output logic        xfer_complete_o,
    output logic        block_gap_o,
    output logic        timeout_err_o
);

    dat_state_e  state;
    logic        read_q;
    logic [15:0] remaining;
    logic [15:0] rem_dec;
    logic        last_block;
    logic        running;
    logic        timeout;
    dat_state_e  resume_state;
    dat_state_e  eob_state;

    assign rem_dec      = remaining - 16'd1;
    assign last_block   = (rem_dec == 16'd0);
    assign resume_state = read_q ? ST_WAIT_START : ST_TX_WAIT_BUF;
    assign eob_state    = last_block    ? ST_IDLE :
                          stop_at_gap_i ? ST_GAP  : resume_state;

    // Timed waits: start bit (only while the host can accept data) and busy.
    // Every timed state is entered from an untimed one, so the counter has
    // always been cleared for at least one cycle on entry.
    assign running = ((state == ST_WAIT_START) && buffer_ready_i) ||
                     (state == ST_WAIT_BUSY);

    assign xfer_active_o = (state != ST_IDLE);

    dat_timeout #(
        .COUNTER_WIDTH (TIMEOUT_COUNTER_WIDTH)
    ) u_timeout (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .running_i      (running),
        .timeout_bits_i (timeout_bits_i),
        .timeout_o      (timeout)
    );

    // Transfer FSM with registered one-cycle status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= ST_IDLE;
            read_q          <= 1'b0;
            remaining       <= '0;
            xfer_complete_o <= 1'b0;
            block_gap_o     <= 1'b0;
            timeout_err_o   <= 1'b0;
        end else begin
            xfer_complete_o <= 1'b0;
            block_gap_o     <= 1'b0;
            timeout_err_o   <= 1'b0;
            if (abort_i) begin
                state     <= ST_IDLE;
                remaining <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (xfer_start_i) begin
                            read_q <= dir_read_i;
                            if (multi_block_i && (block_count_i == 16'd0)) begin
                                // Nothing to move: report done without leaving IDLE.
                                remaining       <= '0;
                                xfer_complete_o <= 1'b1;
                            end else begin
                                remaining <= multi_block_i ? block_count_i : 16'd1;
                                state     <= dir_read_i ? ST_WAIT_START : ST_TX_WAIT_BUF;
                            end
                        end
                    end
                    ST_WAIT_START: begin
                        // A start bit arriving with the timeout still counts as progress.
                        if (dat_start_bit_i) begin
                            state <= ST_RX_BLOCK;
                        end else if (timeout) begin
                            state         <= ST_ERROR;
                            timeout_err_o <= 1'b1;
                        end
                    end
                    ST_RX_BLOCK: begin
                        if (block_done_i) begin
                            remaining       <= rem_dec;
                            state           <= eob_state;
                            xfer_complete_o <= last_block;
                            block_gap_o     <= !last_block && stop_at_gap_i;
                        end
                    end
                    ST_TX_WAIT_BUF: begin
                        if (buffer_ready_i) begin
                            state <= ST_TX_BLOCK;
                        end
                    end
                    ST_TX_BLOCK: begin
                        if (block_done_i) begin
                            state <= ST_WAIT_BUSY;
                        end
                    end
                    ST_WAIT_BUSY: begin
                        if (!dat0_busy_i) begin
                            remaining       <= rem_dec;
                            state           <= eob_state;
                            xfer_complete_o <= last_block;
                            block_gap_o     <= !last_block && stop_at_gap_i;
                        end else if (timeout) begin
                            state         <= ST_ERROR;
                            timeout_err_o <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (continue_i) begin
                            state <= resume_state;
                        end
                    end
                    ST_ERROR: begin
                        // Held until software aborts the DAT line.
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
